// File: rtl/comb_chk_pkg.sv
// Shared types and constants for the combinational-response checker.
// Included by every file of the comb_response_checker slice.
package comb_chk_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    typedef logic [2:0] vec_idx_t;

    localparam logic [7:0] FULL_COV = 8'hFF;

endpackage

// File: rtl/comb_response_checker_if.sv
// Stimulus/response bundle seen by the checker: applied vector {x,y,z},
// observed outputs {f1,f2,f3} and the qualifying valid.
interface comb_response_checker_if;

    logic vld;
    logic x, y, z;
    logic f1, f2, f3;

    modport master (output vld, x, y, z, f1, f2, f3);
    modport slave  (input  vld, x, y, z, f1, f2, f3);

endinterface

// File: rtl/comb_golden_lut.sv
// Golden truth-table lookup: expected {F1,F2,F3} for a 3-bit input vector.
module comb_golden_lut
    import comb_chk_pkg::*;
#(
    parameter logic [7:0] TRUTH_F1 = 8'h96,
    parameter logic [7:0] TRUTH_F2 = 8'hE8,
    parameter logic [7:0] TRUTH_F3 = 8'h80
) (
    input  vec_idx_t   idx,
    output logic [2:0] exp
);

    assign exp = {TRUTH_F1[idx], TRUTH_F2[idx], TRUTH_F3[idx]};

endmodule

// File: rtl/comb_response_checker.sv
// Sequential self-checker comparing observed {f1,f2,f3} against a golden table.
// Optional coverage tracking enabled by defining COMB_CHK_COVERAGE_EN.
module comb_response_checker
    import comb_chk_pkg::*;
#(
    parameter logic [7:0] TRUTH_F1 = 8'h96,
    parameter logic [7:0] TRUTH_F2 = 8'hE8,
    parameter logic [7:0] TRUTH_F3 = 8'h80,
    parameter int         NUM_VEC  = 8,
    parameter int         CNT_W    = 4
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    start,
    comb_response_checker_if.slave  stim,
    output logic                    busy,
    output logic                    done,
    output logic                    pass,
    output logic [CNT_W-1:0]        err_cnt,
    output logic                    first_fail_vld,
    output logic [2:0]              first_fail_idx,
    output logic [7:0]              cov
);

    state_t     state;
    logic [7:0] vec_cnt;
    vec_idx_t   idx;
    logic [2:0] exp_f;
    logic [2:0] obs_f;
    logic       mismatch;
    logic       sample;
    logic       last_sample;
    logic [CNT_W-1:0] err_nxt;
    logic       pass_nxt;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (&v) ? v : v + 1'b1;
    endfunction

    assign idx   = {stim.x, stim.y, stim.z};
    assign obs_f = {stim.f1, stim.f2, stim.f3};

    comb_golden_lut #(
        .TRUTH_F1 (TRUTH_F1),
        .TRUTH_F2 (TRUTH_F2),
        .TRUTH_F3 (TRUTH_F3)
    ) u_lut (
        .idx (idx),
        .exp (exp_f)
    );

    // start always wins over a concurrent vld, so a restart never samples
    assign sample      = (state == RUN) && !start && stim.vld;
    assign last_sample = sample && (vec_cnt == 8'(NUM_VEC - 1));
    assign mismatch    = (obs_f != exp_f);

`ifdef COMB_CHK_COVERAGE_EN
    logic [7:0] cov_q;
    logic [7:0] cov_nxt;

    always_comb begin
        cov_nxt  = cov_q | (8'b1 << idx);
        err_nxt  = mismatch ? sat_inc(err_cnt) : err_cnt;
        pass_nxt = (err_nxt == '0) && (cov_nxt == FULL_COV);
    end

    always_ff @(posedge clk) begin
        if (!rst_n || start) begin
            cov_q <= '0;
        end else if (sample) begin
            cov_q <= cov_nxt;
        end
    end

    assign cov = cov_q;
`else
    always_comb begin
        err_nxt  = mismatch ? sat_inc(err_cnt) : err_cnt;
        pass_nxt = (err_nxt == '0);
    end

    assign cov = 8'h00;
`endif

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state          <= IDLE;
            busy           <= 1'b0;
            done           <= 1'b0;
            pass           <= 1'b0;
            err_cnt        <= '0;
            first_fail_vld <= 1'b0;
            first_fail_idx <= '0;
            vec_cnt        <= '0;
        end else begin
            case (state)
                IDLE, DONE, RUN: begin
                    if (start) begin
                        state          <= RUN;
                        busy           <= 1'b1;
                        done           <= 1'b0;
                        pass           <= 1'b0;
                        err_cnt        <= '0;
                        first_fail_vld <= 1'b0;
                        first_fail_idx <= '0;
                        vec_cnt        <= '0;
                    end else if (sample) begin
                        vec_cnt <= vec_cnt + 8'd1;
                        err_cnt <= err_nxt;
                        if (mismatch && !first_fail_vld) begin
                            first_fail_vld <= 1'b1;
                            first_fail_idx <= idx;
                        end
                        if (last_sample) begin
                            state <= DONE;
                            busy  <= 1'b0;
                            done  <= 1'b1;
                            pass  <= pass_nxt;
                        end
                    end
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                    done  <= 1'b0;
                    pass  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_comb_response_checker.sv
// Randomized scoreboard bench for comb_response_checker (default and CNT_W=2
// instances share stimulus; a behavioural model predicts each run's result).
module tb_comb_response_checker;
    localparam int NUM_VEC = 8;

    logic clk = 1'b0;
    logic rst_n;
    logic start;

    comb_response_checker_if sif();

    logic       busy, done, pass, ff_vld;
    logic [3:0] err_cnt;
    logic [2:0] ff_idx;
    logic [7:0] cov;
    logic       busy2, done2, pass2, ff_vld2;
    logic [1:0] err_cnt2;
    logic [2:0] ff_idx2;
    logic [7:0] cov2;

    comb_response_checker dut (
        .clk(clk), .rst_n(rst_n), .start(start), .stim(sif),
        .busy(busy), .done(done), .pass(pass), .err_cnt(err_cnt),
        .first_fail_vld(ff_vld), .first_fail_idx(ff_idx), .cov(cov)
    );

    comb_response_checker #(.CNT_W(2)) dut2 (
        .clk(clk), .rst_n(rst_n), .start(start), .stim(sif),
        .busy(busy2), .done(done2), .pass(pass2), .err_cnt(err_cnt2),
        .first_fail_vld(ff_vld2), .first_fail_idx(ff_idx2), .cov(cov2)
    );

    always #5 clk = ~clk;

    longint cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input longint act, input longint expv);
        checks++;
        if (act != expv) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, expv, cyc);
        end
    endtask

    // Golden functions written from their meaning: parity, majority, AND
    function automatic logic [2:0] golden(input logic [2:0] v);
        int ones;
        ones = v[2] + v[1] + v[0];
        return {logic'(ones % 2 == 1), logic'(ones >= 2), logic'(ones == 3)};
    endfunction

    typedef struct {
        int         err;
        bit         ffv;
        logic [2:0] ffi;
        bit         ps;
        logic [7:0] cv;
        longint     cyc;
    } exp_t;

    exp_t sb[$];

    bit         m_run;
    int         m_cnt, m_err;
    bit         m_ffv;
    logic [2:0] m_ffi;
    logic [7:0] m_cov;

    function automatic void model_clear();
        m_cnt = 0; m_err = 0; m_ffv = 0; m_ffi = 0; m_cov = 0;
    endfunction

    function automatic void model_step(input bit st, input bit v,
                                       input logic [2:0] idx, input logic [2:0] f);
        exp_t e;
        if (!rst_n) begin
            m_run = 0;
            model_clear();
        end else if (st) begin
            m_run = 1;
            model_clear();
        end else if (m_run && v) begin
            m_cnt++;
            m_cov[idx] = 1'b1;
            if (f != golden(idx)) begin
                m_err++;
                if (!m_ffv) begin m_ffv = 1; m_ffi = idx; end
            end
            if (m_cnt == NUM_VEC) begin
                m_run  = 0;
                e.err  = m_err;
                e.ffv  = m_ffv;
                e.ffi  = m_ffi;
`ifdef COMB_CHK_COVERAGE_EN
                e.cv   = m_cov;
                e.ps   = (m_err == 0) && (m_cov == 8'hFF);
`else
                e.cv   = 8'h00;
                e.ps   = (m_err == 0);
`endif
                e.cyc  = cyc + 1;
                sb.push_back(e);
            end
        end
    endfunction

    task automatic apply(input bit st, input bit v, input logic [2:0] idx, input logic [2:0] f);
        start = st;
        sif.vld = v;
        {sif.x, sif.y, sif.z} = idx;
        {sif.f1, sif.f2, sif.f3} = f;
        model_step(st, v, idx, f);
        @(posedge clk);
        #1;
        start = 1'b0;
        sif.vld = 1'b0;
    endtask

    task automatic gap();
        int n;
        n = $urandom_range(0, 2);
        for (int i = 0; i < n; i++)
            apply(0, 0, 3'($urandom), 3'($urandom));
    endtask

    task automatic check_idle(input string tag);
        check({tag, "_busy"}, busy, 0);
        check({tag, "_done"}, done, 0);
        check({tag, "_pass"}, pass, 0);
        check({tag, "_err"}, err_cnt, 0);
        check({tag, "_ffvld"}, ff_vld, 0);
        check({tag, "_cov"}, cov, 0);
        check({tag, "_err2"}, err_cnt2, 0);
    endtask

    // Monitor: compare on every rising edge of done
    bit done_d = 0;
    always @(negedge clk) begin
        exp_t e;
        if (done && !done_d) begin
            if (sb.size() == 0) begin
                check("unexpected_done", 1, 0);
            end else begin
                e = sb.pop_front();
                check("done_cycle", cyc, e.cyc);
                check("err_cnt", err_cnt, (e.err > 15) ? 15 : e.err);
                check("err_cnt_w2", err_cnt2, (e.err > 3) ? 3 : e.err);
                check("first_fail_vld", ff_vld, e.ffv);
                check("first_fail_idx", ff_idx, e.ffi);
                check("pass", pass, e.ps);
                check("pass_w2", pass2, e.ps);
                check("cov", cov, e.cv);
                check("done_w2", done2, 1);
            end
        end
        if (!done) check("pass_without_done", pass, 0);
        done_d <= done;
    end

    initial begin
        logic [2:0] i3;
        logic [2:0] fbad;
        int n;
        rst_n = 1'b0;
        start = 1'b0;
        sif.vld = 1'b0;
        {sif.x, sif.y, sif.z, sif.f1, sif.f2, sif.f3} = '0;
        m_run = 0;
        model_clear();

        // Reset with random inputs
        for (int i = 0; i < 2; i++)
            apply(1'($urandom), 1'($urandom), 3'($urandom), 3'($urandom));
        check_idle("reset");
        rst_n = 1'b1;
        apply(0, 0, 0, 0);

        // All eight vectors correct
        apply(1, 0, 0, 0);
        for (int i = 0; i < 8; i++) apply(0, 1, 3'(i), golden(3'(i)));
        apply(0, 0, 0, 0);
        // vld in DONE is ignored
        apply(0, 1, 3'd0, ~golden(3'd0));
        check("done_hold", done, 1);
        check("done_err_hold", err_cnt, 0);

        // Single mismatch at idx 3
        apply(1, 0, 0, 0);
        for (int i = 0; i < 8; i++)
            apply(0, 1, 3'(i), (i == 3) ? 3'b000 : golden(3'(i)));
        apply(0, 0, 0, 0);

        // Correct but incomplete coverage
        apply(1, 0, 0, 0);
        for (int i = 0; i < 8; i++) apply(0, 1, 3'd0, golden(3'd0));
        apply(0, 0, 0, 0);

        // Reset mid-run, vld without start, then start with concurrent vld
        apply(1, 0, 0, 0);
        for (int i = 0; i < 4; i++) apply(0, 1, 3'(i), ~golden(3'(i)));
        rst_n = 1'b0;
        apply(0, 1, 3'd5, 3'd0);
        rst_n = 1'b1;
        check_idle("midrun_reset");
        for (int i = 0; i < 3; i++) apply(0, 1, 3'(i), ~golden(3'(i)));
        check_idle("vld_no_start");
        apply(1, 1, 3'd7, 3'd0);
        for (int i = 0; i < 8; i++) apply(0, 1, 3'(7 - i), golden(3'(7 - i)));
        apply(0, 0, 0, 0);

        // Restart while running discards concurrent sample
        apply(1, 0, 0, 0);
        for (int i = 0; i < 3; i++) apply(0, 1, 3'(i), ~golden(3'(i)));
        apply(1, 1, 3'd6, ~golden(3'd6));
        check("restart_busy", busy, 1);
        check("restart_err", err_cnt, 0);
        check("restart_ffvld", ff_vld, 0);
        for (int i = 0; i < 8; i++) begin
            gap();
            apply(0, 1, 3'(i), golden(3'(i)));
        end
        apply(0, 0, 0, 0);

        // Eight wrong vectors: saturation in the CNT_W=2 instance
        apply(1, 0, 0, 0);
        for (int i = 0; i < 8; i++) begin
            i3 = 3'($urandom);
            fbad = golden(i3) ^ 3'($urandom_range(1, 7));
            apply(0, 1, i3, fbad);
        end
        apply(0, 0, 0, 0);
        // start in DONE clears and re-enters RUN
        apply(1, 0, 0, 0);
        check("done_restart_busy", busy, 1);
        check("done_restart_done", done, 0);
        check("done_restart_err", err_cnt, 0);
        check("done_restart_err2", err_cnt2, 0);
        for (int i = 0; i < 8; i++) apply(0, 1, 3'(i), golden(3'(i)));
        apply(0, 0, 0, 0);

        // Randomized runs
        for (int r = 0; r < 12; r++) begin
            apply(1, 0, 0, 0);
            for (int i = 0; i < NUM_VEC; i++) begin
                gap();
                i3 = 3'($urandom);
                fbad = ($urandom_range(0, 9) < 2) ? 3'($urandom_range(1, 7)) : 3'd0;
                apply(0, 1, i3, golden(i3) ^ fbad);
            end
            apply(0, 0, 0, 0);
        end

        // Drain scoreboard with a bounded wait
        n = 0;
        while (sb.size() != 0 && n < 20) begin
            apply(0, 0, 0, 0);
            n++;
        end
        apply(0, 0, 0, 0);
        check("scoreboard_drained", sb.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
